// File: rtl/selection_sort_ctrl.sv
// Selection-sort control/compare stage: scans a synchronous-read array, strobes the
// external running-minimum register, and swaps each pass's minimum into position i.
module selection_sort_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_upd_sel,
    output logic                  o_upd_en,
    output logic [DATA_WIDTH-1:0] o_value_i,
    output logic [DATA_WIDTH-1:0] o_value_j,
    input  logic [DATA_WIDTH-1:0] i_value_smallest
);

    localparam logic [ADDR_WIDTH:0]   MAX_LEN_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   TWO_C     = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
    localparam logic [ADDR_WIDTH:0]   ONE_LEN_C = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_I   = 4'd1,
        S_LD_I   = 4'd2,
        S_RD_J   = 4'd3,
        S_CMP    = 4'd4,
        S_SWAP_A = 4'd5,
        S_SWAP_B = 4'd6,
        S_NEXT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   i_idx_r, i_idx_s;
    logic [ADDR_WIDTH-1:0]   j_idx_r, j_idx_s;
    logic [ADDR_WIDTH-1:0]   min_idx_r, min_idx_s;
    logic [DATA_WIDTH-1:0]   val_i_r, val_i_s;
    logic [ADDR_WIDTH:0]     len_r, len_s;
    logic [ADDR_WIDTH:0]     len_clamp_s;
    logic [ADDR_WIDTH:0]     len_m1_s;
    logic [ADDR_WIDTH-1:0]   i_next_s;

    // State and datapath registers; reset clears everything so no write can follow reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_IDLE;
            i_idx_r   <= {ADDR_WIDTH{1'b0}};
            j_idx_r   <= {ADDR_WIDTH{1'b0}};
            min_idx_r <= {ADDR_WIDTH{1'b0}};
            val_i_r   <= {DATA_WIDTH{1'b0}};
            len_r     <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            state_r   <= state_s;
            i_idx_r   <= i_idx_s;
            j_idx_r   <= j_idx_s;
            min_idx_r <= min_idx_s;
            val_i_r   <= val_i_s;
            len_r     <= len_s;
        end
    end

    // Next-state logic and strobes; read data is consumed the cycle it arrives
    always_comb begin
        state_s     = state_r;
        i_idx_s     = i_idx_r;
        j_idx_s     = j_idx_r;
        min_idx_s   = min_idx_r;
        val_i_s     = val_i_r;
        len_s       = len_r;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_rd_en     = 1'b0;
        o_rd_addr   = {ADDR_WIDTH{1'b0}};
        o_wr_en     = 1'b0;
        o_wr_addr   = {ADDR_WIDTH{1'b0}};
        o_wr_data   = {DATA_WIDTH{1'b0}};
        o_upd_sel   = 1'b0;
        o_upd_en    = 1'b0;
        o_value_i   = {DATA_WIDTH{1'b0}};
        o_value_j   = {DATA_WIDTH{1'b0}};
        len_clamp_s = (i_len > MAX_LEN_C) ? MAX_LEN_C : i_len;
        len_m1_s    = len_r - ONE_LEN_C;
        i_next_s    = i_idx_r + ONE_IDX_C;

        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    len_s   = len_clamp_s;
                    i_idx_s = {ADDR_WIDTH{1'b0}};
                    state_s = (len_clamp_s < TWO_C) ? S_DONE : S_RD_I;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_I: begin
                o_busy    = 1'b1;
                o_rd_en   = 1'b1;
                o_rd_addr = i_idx_r;
                state_s   = S_LD_I;
            end
            S_LD_I: begin
                o_busy    = 1'b1;
                o_value_i = i_rd_data;
                o_upd_sel = 1'b1;
                val_i_s   = i_rd_data;
                min_idx_s = i_idx_r;
                j_idx_s   = i_next_s;
                state_s   = S_RD_J;
            end
            S_RD_J: begin
                o_busy    = 1'b1;
                o_rd_en   = 1'b1;
                o_rd_addr = j_idx_r;
                state_s   = S_CMP;
            end
            S_CMP: begin
                o_busy    = 1'b1;
                o_value_j = i_rd_data;
                // Strict compare keeps the first occurrence on ties
                if (i_rd_data < i_value_smallest) begin
                    o_upd_en  = 1'b1;
                    min_idx_s = j_idx_r;
                end else begin
                    o_upd_en  = 1'b0;
                    min_idx_s = min_idx_r;
                end
                if ({1'b0, j_idx_r} == len_m1_s) begin
                    state_s = S_SWAP_A;
                end else begin
                    j_idx_s = j_idx_r + ONE_IDX_C;
                    state_s = S_RD_J;
                end
            end
            S_SWAP_A: begin
                o_busy = 1'b1;
                if (min_idx_r != i_idx_r) begin
                    o_wr_en   = 1'b1;
                    o_wr_addr = min_idx_r;
                    o_wr_data = val_i_r;
                end else begin
                    o_wr_en   = 1'b0;
                end
                state_s = S_SWAP_B;
            end
            S_SWAP_B: begin
                o_busy = 1'b1;
                if (min_idx_r != i_idx_r) begin
                    o_wr_en   = 1'b1;
                    o_wr_addr = i_idx_r;
                    o_wr_data = i_value_smallest;
                end else begin
                    o_wr_en   = 1'b0;
                end
                state_s = S_NEXT;
            end
            S_NEXT: begin
                o_busy  = 1'b1;
                i_idx_s = i_next_s;
                if ({1'b0, i_next_s} == len_m1_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RD_I;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_selection_sort_ctrl.sv
// Bench for selection_sort_ctrl: models the array and the running-minimum register,
// and compares results against a plain selection-sort reference.
module tb_selection_sort_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len_drv = '0;
    logic          busy, done, rd_en, wr_en, upd_sel, upd_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data, value_i, value_j;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] min_q = '0;

    logic [DW-1:0] mem [DEPTH];

    logic          l_rd_en = 1'b0, l_wr_en = 1'b0, l_sel = 1'b0, l_en = 1'b0;
    logic [AW-1:0] l_rd_addr = '0, l_wr_addr = '0;
    logic [DW-1:0] l_wr_data = '0, l_vi = '0, l_vj = '0;

    int vectors = 0;
    int miscompares = 0;
    int busy_cnt, done_cnt, done_at, rd_cnt, wr_cnt, sel_cnt, en_cnt, overlap_cnt, sample_idx;
    int wr_log_addr [$];
    int wr_log_data [$];

    always #5 clk = ~clk;

    selection_sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_len            (len_drv),
        .o_busy           (busy),
        .o_done           (done),
        .o_rd_en          (rd_en),
        .o_rd_addr        (rd_addr),
        .i_rd_data        (rd_data),
        .o_wr_en          (wr_en),
        .o_wr_addr        (wr_addr),
        .o_wr_data        (wr_data),
        .o_upd_sel        (upd_sel),
        .o_upd_en         (upd_en),
        .o_value_i        (value_i),
        .o_value_j        (value_j),
        .i_value_smallest (min_q)
    );

    // Sample outputs mid-cycle: count events and latch them for the edge models
    always @(negedge clk) begin
        l_rd_en = rd_en; l_rd_addr = rd_addr;
        l_wr_en = wr_en; l_wr_addr = wr_addr; l_wr_data = wr_data;
        l_sel = upd_sel; l_en = upd_en; l_vi = value_i; l_vj = value_j;
        if (busy) busy_cnt++;
        if (done) begin
            if (done_cnt == 0) done_at = sample_idx;
            done_cnt++;
        end
        if (rd_en) rd_cnt++;
        if (upd_sel) sel_cnt++;
        if (upd_en) en_cnt++;
        if (upd_sel && upd_en) overlap_cnt++;
        if (wr_en) begin
            wr_cnt++;
            wr_log_addr.push_back(int'(wr_addr));
            wr_log_data.push_back(int'(wr_data));
        end
        sample_idx++;
    end

    // Synchronous-read array and running-minimum register models
    always @(posedge clk) begin
        if (rst_n) begin
            if (l_sel) min_q <= l_vi;
            else if (l_en) min_q <= l_vj;
            if (l_rd_en) rd_data <= mem[l_rd_addr];
            if (l_wr_en) mem[l_wr_addr] = l_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic all_outputs_zero(input string tag);
        check(tag, 32'(|{busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
                         upd_sel, upd_en, value_i, value_j}), 32'd0);
    endtask

    task automatic clear_counters();
        busy_cnt = 0; done_cnt = 0; done_at = -1; rd_cnt = 0; wr_cnt = 0;
        sel_cnt = 0; en_cnt = 0; overlap_cnt = 0; sample_idx = 0;
        wr_log_addr.delete(); wr_log_data.delete();
    endtask

    task automatic run_sort(input string tag, input int len_in, input bit extra_start);
        logic [DW-1:0] a [DEPTH];
        logic [DW-1:0] mn, t;
        int len, mi;
        int exp_busy = 0, exp_rd = 0, exp_wr = 0, exp_en = 0;
        len = (len_in > DEPTH) ? DEPTH : len_in;
        for (int k = 0; k < DEPTH; k++) a[k] = mem[k];
        for (int p = 0; p < len - 1; p++) begin
            exp_busy += 5 + 2 * (len - 1 - p);
            exp_rd   += 1 + (len - 1 - p);
            mn = a[p]; mi = p;
            for (int q = p + 1; q < len; q++) begin
                if (a[q] < mn) begin mn = a[q]; mi = q; exp_en++; end
            end
            if (mi != p) begin t = a[p]; a[p] = a[mi]; a[mi] = t; exp_wr += 2; end
        end
        @(negedge clk); #1;
        clear_counters();
        len_drv = len_in[AW:0];
        start = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            start = extra_start && (k == 2 || k == 3);
            if (done_cnt > 0) break;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, exp_busy);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_reads"}, rd_cnt, exp_rd);
        check({tag, "_writes"}, wr_cnt, exp_wr);
        check({tag, "_upd_sel"}, sel_cnt, (len >= 2) ? len - 1 : 0);
        check({tag, "_upd_en"}, en_cnt, exp_en);
        check({tag, "_strobe_overlap"}, overlap_cnt, 0);
        for (int k = 0; k < DEPTH; k++) check($sformatf("%s_a%0d", tag, k), mem[k], a[k]);
    endtask

    initial begin
        logic [DW-1:0] init4 [4];
        logic [DW-1:0] dup5 [5];
        init4 = '{8'd3, 8'd1, 8'd2, 8'd0};
        dup5  = '{8'd2, 8'd2, 8'd0, 8'd255, 8'd0};
        for (int k = 0; k < DEPTH; k++) mem[k] = 8'(k + 100);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 all_outputs_zero("reset_outputs");
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) mem[k] = init4[k];
        run_sort("basic", 4, 1'b0);
        check("basic_busy_27", busy_cnt, 27);

        for (int k = 0; k < 5; k++) mem[k] = 8'(k + 1);
        run_sort("sorted", 5, 1'b0);
        check("sorted_no_writes", wr_cnt, 0);

        for (int k = 0; k < 5; k++) mem[k] = dup5[k];
        run_sort("dups", 5, 1'b0);
        check("dups_w0_addr", (wr_log_addr.size() >= 2) ? wr_log_addr[0] : 99, 2);
        check("dups_w0_data", (wr_log_data.size() >= 2) ? wr_log_data[0] : 99, 2);
        check("dups_w1_addr", (wr_log_addr.size() >= 2) ? wr_log_addr[1] : 99, 0);
        check("dups_w1_data", (wr_log_data.size() >= 2) ? wr_log_data[1] : 99, 0);

        run_sort("len1", 1, 1'b0);
        run_sort("len0", 0, 1'b0);

        for (int k = 0; k < DEPTH; k++) mem[k] = 8'($urandom_range(0, 255));
        run_sort("busy_start", 7, 1'b1);

        for (int k = 0; k < DEPTH; k++) mem[k] = 8'($urandom_range(0, 255));
        run_sort("clamp", 25, 1'b0);

        for (int trial = 0; trial < 6; trial++) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] = 8'((trial % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3));
            run_sort($sformatf("rand%0d", trial), $urandom_range(2, 16), 1'b0);
        end

        for (int k = 0; k < DEPTH; k++) mem[k] = 8'($urandom_range(0, 255));
        @(negedge clk); #1;
        clear_counters();
        len_drv = 5'd16;
        start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 all_outputs_zero("midrst_outputs");
        repeat (3) @(negedge clk);
        #1 all_outputs_zero("midrst_held");
        check("midrst_writes", wr_cnt, 0);
        rst_n = 1'b1;
        run_sort("after_rst", 16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
